fft_input_loader: RTL and testbench
===================================

// Module: fft_input_loader
// PURPOSE
//  Upstream stage of fft_ram_block. Accepts one frame of N complex samples on a valid/ready stream
//  and writes each into one of the 4 RE/IM RAM banks using conflict-free radix-4 bank mapping.
//  Flags the frame as loaded and holds off further input until FFT control releases the buffer.
// PARAMETERS
//  LOG2N   11   log2 of frame length N (2048); must be odd or even, >= 4
//  DW      16   sample width per RE/IM component
//  AW      9    bank address width; fixed to LOG2N-2
// PORTS
//  iCLK         in   1    clock, all logic on rising edge
//  iRESET       in   1    asynchronous, active-low reset
//  iVALID       in   1    input sample valid
//  iDATA_RE     in   DW   input sample, real part (two's complement)
//  iDATA_IM     in   DW   input sample, imaginary part
//  oREADY       out  1    loader accepts a sample this cycle
//  iRELEASE     in   1    FFT control frees the buffer; next frame may load
//  oFULL        out  1    frame of N samples written, buffer owned by FFT core
//  oCOUNT       out  LOG2N samples accepted in current frame
//  oDATA_RE_k   out  DW   k=0..3: write data to bank k, real
//  oDATA_IM_k   out  DW   k=0..3: write data to bank k, imaginary
//  oADDR_WR_k   out  AW   k=0..3: write address to bank k
//  oWE_k        out  1    k=0..3: write enable to bank k
// BEHAVIOUR
//  - Reset (iRESET=0): state LOAD, oCOUNT=0, oFULL=0, oREADY=1 after release, all oWE_k=0, oADDR/oDATA=0.
//  - States: LOAD (oREADY=1), FLUSH (last write in flight, oREADY=0), FULL (oREADY=0, oFULL=1).
//  - Accept = iVALID & oREADY. On accept: index i = oCOUNT, oCOUNT++ (wraps to 0 after N-1).
//  - Mapping of i (after optional reorder): digits d_j = i[2j+1:2j], top single bit as its own digit if LOG2N odd;
//    bank = (sum of digits) mod 4; bank address = i[LOG2N-1:2]. Groups i[1:0]=0..3 hit 4 distinct banks.
//  - Write stage is registered: accept in cycle t -> oWE_bank=1, address and data valid in cycle t+1.
//    Exactly one oWE_k high per cycle at most; data broadcast to all four data ports.
//  - Accept of index N-1: LOAD -> FLUSH; next cycle write completes, FLUSH -> FULL, oFULL=1.
//  - FULL: iVALID ignored (no write, no count change). iRELEASE=1 -> LOAD next cycle, oFULL=0, oCOUNT=0.
//  - iRELEASE in LOAD/FLUSH: ignored. iVALID without oREADY: ignored, no side effects.
//  - Reset mid-frame: partial frame discarded, count to 0, pending write cancelled (oWE_k=0 immediately).
// CONFIGURATION
//  FFT_BITREV_EN defined: index i is bit-reversed over LOG2N bits before bank mapping (natural-order input,
//    DIT in-place layout). Undefined: i used directly (natural-order layout). Count/handshake unaffected.
// STRUCTURE
//  fft_pkg: LOG2N/AW constants, loader state typedef, function for digit-sum bank mapping.
//  Sub-module fft_bank_map: combinational index -> {bank[1:0], addr[AW-1:0]}, reused by read-side address gen.
// TESTING
//  1. Reset, stream samples i=0..4 (RE=i, IM=-i) -> writes: i0 bank0 addr0, i1 bank1 addr0, i2 bank2 addr0,
//     i3 bank3 addr0, i4 (digits 01,00) bank1 addr1; each oWE one cycle after accept.
//  2. Full frame of 2048 with iVALID=1 -> oFULL rises 2 cycles after accept of index 2047 (bank0 addr511),
//     oREADY=0, exactly 2048 writes, each (bank,addr) pair written once.
//  3. In FULL drive iVALID=1 for 10 cycles -> no oWE, oCOUNT stays 0; pulse iRELEASE -> oREADY=1 next cycle.
//  4. Random iVALID gaps (50%) -> bank/addr sequence identical to test 2; no write on idle cycles.
//  5. Assert iRESET at sample 700 -> all oWE_k=0 asynchronously, oCOUNT=0; restart writes index 0 to bank0 addr0.
//  6. With FFT_BITREV_EN: sample 1 -> reversed 1024 -> bank1 addr256; sample 2 -> 512 -> bank2 addr128.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, loader state type and the radix-4 digit-sum bank mapping
// used by the FFT input loader and the read-side address generation.
package fft_pkg;

   localparam int unsigned FftLog2N = 11;
   localparam int unsigned FftAw    = FftLog2N - 2;
   localparam int unsigned FftDw    = 16;

   typedef enum logic [1:0] {
      StLoad,
      StFlush,
      StFull
   } loader_state_e;

   // Sum of base-4 digits mod 4; an odd top bit lands in its own digit because the
   // caller zero-extends the index.
   function automatic logic [1:0] digit_sum_bank(input logic [31:0] idx);
      logic [1:0] sum;
      sum = 2'd0;
      for (int j = 0; j < 16; j++) begin
         sum = sum + idx[2*j +: 2];
      end
      return sum;
   endfunction

endpackage

// File: rtl/fft_bank_map.sv
// Combinational index -> {bank, address} for conflict-free radix-4 bank layout.
module fft_bank_map
   import fft_pkg::*;
#(
   parameter int unsigned LOG2N = FftLog2N,
   parameter int unsigned AW    = LOG2N - 2
) (
   input  logic [LOG2N-1:0] idx_i,
   output logic [1:0]       bank_o,
   output logic [AW-1:0]    addr_o
);

   logic [31:0] idx_ext;

   assign idx_ext = 32'(idx_i);
   assign bank_o  = digit_sum_bank(idx_ext);
   assign addr_o  = idx_i[LOG2N-1:2];

endmodule

// File: rtl/fft_input_loader.sv
// Loads one frame of N complex samples into 4 RE/IM banks, then holds until released.
// Optional FFT_BITREV_EN: bit-reverse the sample index before bank mapping.
module fft_input_loader
   import fft_pkg::*;
#(
   parameter int unsigned LOG2N = FftLog2N,
   parameter int unsigned DW    = FftDw,
   parameter int unsigned AW    = LOG2N - 2
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iVALID,
   input  logic [DW-1:0]    iDATA_RE,
   input  logic [DW-1:0]    iDATA_IM,
   output logic             oREADY,
   input  logic             iRELEASE,
   output logic             oFULL,
   output logic [LOG2N-1:0] oCOUNT,
   output logic [DW-1:0]    oDATA_RE_0,
   output logic [DW-1:0]    oDATA_RE_1,
   output logic [DW-1:0]    oDATA_RE_2,
   output logic [DW-1:0]    oDATA_RE_3,
   output logic [DW-1:0]    oDATA_IM_0,
   output logic [DW-1:0]    oDATA_IM_1,
   output logic [DW-1:0]    oDATA_IM_2,
   output logic [DW-1:0]    oDATA_IM_3,
   output logic [AW-1:0]    oADDR_WR_0,
   output logic [AW-1:0]    oADDR_WR_1,
   output logic [AW-1:0]    oADDR_WR_2,
   output logic [AW-1:0]    oADDR_WR_3,
   output logic             oWE_0,
   output logic             oWE_1,
   output logic             oWE_2,
   output logic             oWE_3
);

   loader_state_e    state_q, state_d;
   logic [LOG2N-1:0] count_q, count_d;
   logic [LOG2N-1:0] map_idx;
   logic [1:0]       bank;
   logic [AW-1:0]    bank_addr;
   logic [AW-1:0]    addr_q, addr_d;
   logic [3:0]       we_q, we_d;
   logic [DW-1:0]    re_q, re_d;
   logic [DW-1:0]    im_q, im_d;
   logic             accept;
   logic             last;

   assign oREADY = (state_q == StLoad);
   assign accept = iVALID & oREADY;
   assign last   = (count_q == {LOG2N{1'b1}});

`ifdef FFT_BITREV_EN
   always_comb begin
      map_idx = '0;
      for (int b = 0; b < int'(LOG2N); b++) begin
         map_idx[b] = count_q[int'(LOG2N) - 1 - b];
      end
   end
`else
   assign map_idx = count_q;
`endif

   fft_bank_map #(
      .LOG2N (LOG2N),
      .AW    (AW)
   ) u_bank_map (
      .idx_i  (map_idx),
      .bank_o (bank),
      .addr_o (bank_addr)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      we_d    = '0;
      addr_d  = addr_q;
      re_d    = re_q;
      im_d    = im_q;
      unique case (state_q)
         StLoad: begin
            if (accept) begin
               count_d = count_q + {{(LOG2N-1){1'b0}}, 1'b1};
               we_d    = 4'b0001 << bank;
               addr_d  = bank_addr;
               re_d    = iDATA_RE;
               im_d    = iDATA_IM;
               if (last) begin
                  state_d = StFlush;
               end
            end
         end
         StFlush: begin
            state_d = StFull;
         end
         StFull: begin
            if (iRELEASE) begin
               state_d = StLoad;
               count_d = '0;
            end
         end
         default: begin
            state_d = StLoad;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_q <= StLoad;
         count_q <= '0;
         we_q    <= '0;
         addr_q  <= '0;
         re_q    <= '0;
         im_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         re_q    <= re_d;
         im_q    <= im_d;
      end
   end

   assign oFULL      = (state_q == StFull);
   assign oCOUNT     = count_q;
   assign oWE_0      = we_q[0];
   assign oWE_1      = we_q[1];
   assign oWE_2      = we_q[2];
   assign oWE_3      = we_q[3];
   assign oADDR_WR_0 = addr_q;
   assign oADDR_WR_1 = addr_q;
   assign oADDR_WR_2 = addr_q;
   assign oADDR_WR_3 = addr_q;
   assign oDATA_RE_0 = re_q;
   assign oDATA_RE_1 = re_q;
   assign oDATA_RE_2 = re_q;
   assign oDATA_RE_3 = re_q;
   assign oDATA_IM_0 = im_q;
   assign oDATA_IM_1 = im_q;
   assign oDATA_IM_2 = im_q;
   assign oDATA_IM_3 = im_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader: arithmetic reference model plus directed frames.
module tb_fft_input_loader;

   localparam int LOG2N = 11;
   localparam int N     = 2048;
   localparam int DW    = 16;
   localparam int AW    = 9;

   logic iCLK = 1'b0;
   logic iRESET = 1'b0;
   logic iVALID = 1'b0;
   logic iRELEASE = 1'b0;
   logic [DW-1:0] iDATA_RE = '0;
   logic [DW-1:0] iDATA_IM = '0;
   logic oREADY, oFULL;
   logic [LOG2N-1:0] oCOUNT;
   logic [DW-1:0] d_re [4];
   logic [DW-1:0] d_im [4];
   logic [AW-1:0] a_w [4];
   logic we_a [4];

   fft_input_loader dut (
      .iCLK       (iCLK),
      .iRESET     (iRESET),
      .iVALID     (iVALID),
      .iDATA_RE   (iDATA_RE),
      .iDATA_IM   (iDATA_IM),
      .oREADY     (oREADY),
      .iRELEASE   (iRELEASE),
      .oFULL      (oFULL),
      .oCOUNT     (oCOUNT),
      .oDATA_RE_0 (d_re[0]),
      .oDATA_RE_1 (d_re[1]),
      .oDATA_RE_2 (d_re[2]),
      .oDATA_RE_3 (d_re[3]),
      .oDATA_IM_0 (d_im[0]),
      .oDATA_IM_1 (d_im[1]),
      .oDATA_IM_2 (d_im[2]),
      .oDATA_IM_3 (d_im[3]),
      .oADDR_WR_0 (a_w[0]),
      .oADDR_WR_1 (a_w[1]),
      .oADDR_WR_2 (a_w[2]),
      .oADDR_WR_3 (a_w[3]),
      .oWE_0      (we_a[0]),
      .oWE_1      (we_a[1]),
      .oWE_2      (we_a[2]),
      .oWE_3      (we_a[3])
   );

   always #5 iCLK = ~iCLK;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int map_idx(input int i);
`ifdef FFT_BITREV_EN
      int r = 0;
      for (int b = 0; b < LOG2N; b++) begin
         if (((i >> b) & 1) != 0) r = r | (1 << (LOG2N - 1 - b));
      end
      return r;
`else
      return i;
`endif
   endfunction

   function automatic int model_bank(input int i);
      int v = map_idx(i);
      int s = 0;
      while (v > 0) begin
         s = s + v % 4;
         v = v / 4;
      end
      return s % 4;
   endfunction

   function automatic int model_addr(input int i);
      return map_idx(i) / 4;
   endfunction

   // phase: 0 loading, 1 last write in flight, 2 full
   int m_count, m_phase, m_bank, m_addr, m_re, m_im;

   always @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         m_count <= 0;
         m_phase <= 0;
         m_bank  <= -1;
         m_addr  <= 0;
         m_re    <= 0;
         m_im    <= 0;
      end else begin
         m_bank <= -1;
         if (m_phase == 0 && iVALID) begin
            m_bank  <= model_bank(m_count);
            m_addr  <= model_addr(m_count);
            m_re    <= int'(iDATA_RE);
            m_im    <= int'(iDATA_IM);
            m_count <= (m_count + 1) % N;
            if (m_count == N - 1) m_phase <= 1;
         end else if (m_phase == 1) begin
            m_phase <= 2;
         end else if (m_phase == 2 && iRELEASE) begin
            m_phase <= 0;
            m_count <= 0;
         end
      end
   end

   typedef struct {
      int bank;
      int addr;
      int re;
   } wr_t;

   wr_t log_q[$];

   always @(negedge iCLK) begin : compare
      int we_act;
      int we_exp;
      we_act = 0;
      for (int k = 0; k < 4; k++) if (we_a[k]) we_act = we_act | (1 << k);
      we_exp = (m_bank < 0) ? 0 : (1 << m_bank);
      chk("ready", int'(oREADY), int'(m_phase == 0));
      chk("full", int'(oFULL), int'(m_phase == 2));
      chk("count", int'(oCOUNT), m_count);
      chk("we", we_act, we_exp);
      for (int k = 0; k < 4; k++) begin
         chk("addr", int'(a_w[k]), m_addr);
         chk("data_re", int'(d_re[k]), m_re);
         chk("data_im", int'(d_im[k]), m_im);
      end
      if (we_act != 0) begin
         wr_t w;
         w.bank = 0;
         for (int k = 3; k >= 0; k--) if (we_a[k]) w.bank = k;
         w.addr = int'(a_w[0]);
         w.re   = int'(d_re[0]);
         log_q.push_back(w);
      end
   end

   // ---------------- stimulus ----------------
   int data_idx = 0;

   task automatic stream(input int n, input bit gaps);
      int sent = 0;
      int budget = 0;
      bit accepted;
      while (sent < n && budget < 20000) begin
         @(negedge iCLK);
         #1;
         budget++;
         iVALID = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
         iDATA_RE = DW'(data_idx);
         iDATA_IM = DW'(0 - data_idx);
         accepted = iVALID && oREADY;
         @(posedge iCLK);
         if (accepted) begin
            sent++;
            data_idx++;
         end
      end
      #1 iVALID = 1'b0;
      if (sent < n) chk("stream_timeout", sent, n);
   endtask

   task automatic release_buf();
      @(negedge iCLK);
      #1 iRELEASE = 1'b1;
      @(posedge iCLK);
      #1 iRELEASE = 1'b0;
      @(negedge iCLK);
      #1 chk("ready_after_release", int'(oREADY), 1);
   endtask

   wr_t seq2[$];
   int pair_cnt [4][512];
   int exp_b1 [5];
   int exp_a1 [5];

   initial begin
`ifdef FFT_BITREV_EN
      exp_b1 = '{0, 1, 2, 3, 1};
      exp_a1 = '{0, 256, 128, 384, 64};
`else
      exp_b1 = '{0, 1, 2, 3, 1};
      exp_a1 = '{0, 0, 0, 0, 1};
`endif
      repeat (3) @(negedge iCLK);
      #2 iRESET = 1'b1;
      @(negedge iCLK);
      #1;
      chk("rst_count", int'(oCOUNT), 0);
      chk("rst_full", int'(oFULL), 0);
      chk("rst_ready", int'(oREADY), 1);
      chk("rst_we0", int'(we_a[0]), 0);

      // first five samples, literal bank/address placement
      log_q.delete();
      data_idx = 0;
      stream(5, 1'b0);
      @(negedge iCLK);
      #1;
      chk("t1_writes", log_q.size(), 5);
      for (int i = 0; i < 5 && i < log_q.size(); i++) begin
         chk("t1_bank", log_q[i].bank, exp_b1[i]);
         chk("t1_addr", log_q[i].addr, exp_a1[i]);
         chk("t1_re", log_q[i].re, i);
      end

      @(negedge iCLK);
      #1 iRESET = 1'b0;
      @(negedge iCLK);
      #1 iRESET = 1'b1;

      // full back-to-back frame
      log_q.delete();
      data_idx = 0;
      stream(N, 1'b0);
      @(negedge iCLK);
      #1;
      chk("flush_full", int'(oFULL), 0);
      chk("flush_we0", int'(we_a[0]), 1);
      chk("flush_addr", int'(a_w[0]), 511);
      @(negedge iCLK);
      #1;
      chk("full_set", int'(oFULL), 1);
      chk("full_ready", int'(oREADY), 0);
      chk("t2_writes", log_q.size(), N);
      for (int b = 0; b < 4; b++) for (int a = 0; a < 512; a++) pair_cnt[b][a] = 0;
      foreach (log_q[i]) pair_cnt[log_q[i].bank][log_q[i].addr % 512]++;
      begin
         int dup = 0;
         for (int b = 0; b < 4; b++) for (int a = 0; a < 512; a++) if (pair_cnt[b][a] != 1) dup++;
         chk("t2_pairs_once", dup, 0);
      end
      seq2 = log_q;

      // input ignored while full
      log_q.delete();
      repeat (10) begin
         @(negedge iCLK);
         #1 iVALID = 1'b1;
      end
      @(negedge iCLK);
      #1 iVALID = 1'b0;
      chk("t3_no_write", log_q.size(), 0);
      chk("t3_count", int'(oCOUNT), 0);
      release_buf();

      // gapped frame must reproduce the same placement
      log_q.delete();
      data_idx = 0;
      stream(N, 1'b1);
      repeat (2) @(negedge iCLK);
      #1;
      chk("t4_full", int'(oFULL), 1);
      chk("t4_writes", log_q.size(), N);
      begin
         int mism = 0;
         for (int i = 0; i < N && i < log_q.size() && i < seq2.size(); i++) begin
            if (log_q[i].bank != seq2[i].bank || log_q[i].addr != seq2[i].addr) mism++;
         end
         chk("t4_seq", mism, 0);
      end
      release_buf();

      // reset mid-frame with a write in flight
      log_q.delete();
      data_idx = 0;
      stream(700, 1'b0);
      #1 iRESET = 1'b0;
      #1;
      chk("t5_we_cleared", int'(we_a[0]) + int'(we_a[1]) + int'(we_a[2]) + int'(we_a[3]), 0);
      chk("t5_count", int'(oCOUNT), 0);
      repeat (2) @(negedge iCLK);
      #2 iRESET = 1'b1;
      log_q.delete();
      data_idx = 0;
      stream(1, 1'b0);
      @(negedge iCLK);
      #1;
      chk("t5_restart_writes", log_q.size(), 1);
      if (log_q.size() > 0) begin
         chk("t5_restart_bank", log_q[0].bank, 0);
         chk("t5_restart_addr", log_q[0].addr, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
